// File: rtl/wb_timer_if.sv
// Wishbone classic slave bus bundle for wb_timer (32-bit data, byte address).
interface wb_timer_if;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        ack;

  modport master (output adr, dat_w, sel, cti, we, cyc, stb, input dat_r, ack);
  modport slave  (input adr, dat_w, sel, cti, we, cyc, stb, output dat_r, ack);
endinterface

// File: rtl/wb_timer.sv
// Dual-channel 32-bit countdown timer with per-channel level interrupts,
// exposed as eight Wishbone registers (adr[4] channel, adr[3:2] register).
module wb_timer #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  wb_timer_if.slave  wb,
  output logic [1:0] irq_o
);

  localparam int unsigned DW     = 32;
  localparam int unsigned NCH    = 2;
  localparam int unsigned PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {
    REG_CTRL   = 2'd0,
    REG_RELOAD = 2'd1,
    REG_COUNT  = 2'd2,
    REG_STATUS = 2'd3
  } reg_e;

  logic [PCNT_W-1:0] pcnt;
  logic              tick;
  logic              req;
  logic              wr;
  logic              ch_sel;
  reg_e              reg_sel;
  logic [DW-1:0]     rd_data;
  logic              unused_bits;

  logic [NCH-1:0] en_q, en_d, ar_q, ar_d, ie_q, ie_d, zf_q, zf_d;
  logic [NCH-1:0] hit, zero_evt;
  logic [DW-1:0]  reload_q [NCH];
  logic [DW-1:0]  reload_d [NCH];
  logic [DW-1:0]  count_q  [NCH];
  logic [DW-1:0]  count_d  [NCH];

  // The ack term masks the request so every transfer takes exactly two cycles.
  assign req         = wb.cyc & wb.stb & ~wb.ack;
  assign wr          = req & wb.we;
  assign ch_sel      = wb.adr[4];
  assign reg_sel     = reg_e'(wb.adr[3:2]);
  assign tick        = (pcnt == PCNT_W'(PRESCALE - 1));
  assign irq_o       = zf_q & ie_q;
  assign unused_bits = ^{wb.cti, wb.adr[31:5], wb.adr[1:0]};

  function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] cur,
                                               input logic [DW-1:0] wdat,
                                               input logic [3:0]    be);
    logic [DW-1:0] res;
    res = cur;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) res[8*b +: 8] = wdat[8*b +: 8];
    end
    return res;
  endfunction

  // Shared free-running prescaler.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)  pcnt <= '0;
    else if (tick)   pcnt <= '0;
    else             pcnt <= pcnt + PCNT_W'(1);
  end

  // Channel next-state: tick update first, then bus write overrides, zero event sets ZF last.
  always_comb begin
    for (int ch = 0; ch < NCH; ch++) begin
      en_d[ch]     = en_q[ch];
      ar_d[ch]     = ar_q[ch];
      ie_d[ch]     = ie_q[ch];
      zf_d[ch]     = zf_q[ch];
      reload_d[ch] = reload_q[ch];
      count_d[ch]  = count_q[ch];
      zero_evt[ch] = 1'b0;
      hit[ch]      = wr && (ch_sel == 1'(ch));

      if (tick && en_q[ch]) begin
        if (count_q[ch] != '0) begin
          count_d[ch] = count_q[ch] - DW'(1);
        end else begin
          zero_evt[ch] = 1'b1;
          if (ar_q[ch]) count_d[ch] = reload_q[ch];
          else          en_d[ch]    = 1'b0;
        end
      end

      if (hit[ch]) begin
        case (reg_sel)
          REG_CTRL:   if (wb.sel[0]) {ie_d[ch], ar_d[ch], en_d[ch]} = wb.dat_w[2:0];
          REG_RELOAD: reload_d[ch] = byte_merge(reload_q[ch], wb.dat_w, wb.sel);
          REG_COUNT:  count_d[ch]  = byte_merge(count_d[ch], wb.dat_w, wb.sel);
          REG_STATUS: if (wb.sel[0] && wb.dat_w[0]) zf_d[ch] = 1'b0;
          default:    ;
        endcase
      end

      if (zero_evt[ch]) zf_d[ch] = 1'b1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_q <= '0;
      ar_q <= '0;
      ie_q <= '0;
      zf_q <= '0;
      for (int ch = 0; ch < NCH; ch++) begin
        reload_q[ch] <= '0;
        count_q[ch]  <= '0;
      end
    end else begin
      en_q <= en_d;
      ar_q <= ar_d;
      ie_q <= ie_d;
      zf_q <= zf_d;
      for (int ch = 0; ch < NCH; ch++) begin
        reload_q[ch] <= reload_d[ch];
        count_q[ch]  <= count_d[ch];
      end
    end
  end

  // Read mux sees pre-update register values.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_CTRL:   rd_data = {29'd0, ie_q[ch_sel], ar_q[ch_sel], en_q[ch_sel]};
      REG_RELOAD: rd_data = reload_q[ch_sel];
      REG_COUNT:  rd_data = count_q[ch_sel];
      REG_STATUS: rd_data = {31'd0, zf_q[ch_sel]};
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wb.ack   <= 1'b0;
      wb.dat_r <= '0;
    end else begin
      wb.ack <= req;
      if (req) wb.dat_r <= rd_data;
    end
  end

endmodule

// File: tb/tb_wb_timer.sv
// Scoreboard bench for wb_timer: one instance at PRESCALE=1, one at PRESCALE=4.
module tb_wb_timer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [31:0] adr, dat_w;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic        we, cyc, stb, dsel;
  logic [1:0]  irq1, irq4;

  wb_timer_if b1();
  wb_timer_if b4();

  assign b1.adr = adr;   assign b4.adr = adr;
  assign b1.dat_w = dat_w; assign b4.dat_w = dat_w;
  assign b1.sel = sel;   assign b4.sel = sel;
  assign b1.cti = cti;   assign b4.cti = cti;
  assign b1.we = we;     assign b4.we = we;
  assign b1.stb = stb;   assign b4.stb = stb;
  assign b1.cyc = cyc & ~dsel;
  assign b4.cyc = cyc & dsel;

  wb_timer #(.PRESCALE(1)) dut1 (.sys_clk(clk), .sys_rst_n(rst_n), .wb(b1), .irq_o(irq1));
  wb_timer #(.PRESCALE(4)) dut4 (.sys_clk(clk), .sys_rst_n(rst_n), .wb(b4), .irq_o(irq4));

  wire        ack_m   = dsel ? b4.ack : b1.ack;
  wire [31:0] rdata_m = dsel ? b4.dat_r : b1.dat_r;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Edges since reset release; edge n is a PRESCALE=4 tick when n%4==0.
  int tb_cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) tb_cyc <= 0;
    else        tb_cyc <= tb_cyc + 1;
  end

  typedef struct {
    logic        chk;
    logic [31:0] exp;
    string       tag;
  } sb_t;
  sb_t sb_q[$];

  logic prev_ack = 1'b0;
  always @(negedge clk) begin
    sb_t e;
    if (ack_m) begin
      check("ack_gap", 32'(prev_ack), 32'd0);
      if (sb_q.size() == 0) begin
        check("unexpected_ack", 32'd1, 32'd0);
      end else begin
        e = sb_q.pop_front();
        if (e.chk) check(e.tag, rdata_m, e.exp);
      end
    end
    prev_ack = ack_m;
  end

  task automatic push_exp(input logic chk, input logic [31:0] exp, input string tag);
    sb_t e;
    e.chk = chk; e.exp = exp; e.tag = tag;
    sb_q.push_back(e);
  endtask

  task automatic xfer(input logic d, input logic [7:0] a, input logic w, input logic [31:0] data,
                      input logic [3:0] s, input logic [31:0] exp, input string tag);
    @(posedge clk); #1;
    dsel = d; adr = 32'hA5C3_E000 | 32'(a); we = w; dat_w = data; sel = s;
    cti = 3'b000; cyc = 1'b1; stb = 1'b1;
    push_exp(~w, exp, tag);
    @(posedge clk); #1;
    check({tag, "_ack"}, 32'(ack_m), 32'd1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    @(posedge clk); #1;
    check({tag, "_ack_low"}, 32'(ack_m), 32'd0);
  endtask

  task automatic wr(input logic d, input logic [7:0] a, input logic [31:0] data, input logic [3:0] s);
    xfer(d, a, 1'b1, data, s, 32'd0, "wr");
  endtask

  task automatic rd(input logic d, input logic [7:0] a, input logic [31:0] exp, input string tag);
    xfer(d, a, 1'b0, 32'd0, 4'hF, exp, tag);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int e_edge, t1, zero_edge, exp_mid, rise;
    logic [31:0] bexp [4];

    rst_n = 1'b0; dsel = 1'b0; adr = '0; dat_w = '0; sel = '0; cti = '0;
    we = 1'b0; cyc = 1'b0; stb = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Dirty some state, then reset asynchronously mid-cycle while ack is high.
    wr(0, 8'h00, 32'h5, 4'hF);
    check("pre_reset_irq", 32'(irq1), 32'h1);
    wr(1, 8'h04, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk); #1;
    dsel = 1'b0; adr = 32'h0000_0008; we = 1'b0; cyc = 1'b1; stb = 1'b1;
    @(posedge clk); #2;
    check("pre_reset_ack", 32'(ack_m), 32'd1);
    rst_n = 1'b0;
    #1;
    check("reset_ack", 32'(b1.ack), 32'd0);
    check("reset_irq1", 32'(irq1), 32'd0);
    check("reset_irq4", 32'(irq4), 32'd0);
    check("reset_dat1", b1.dat_r, 32'd0);
    check("reset_dat4", b4.dat_r, 32'd0);
    cyc = 1'b0; stb = 1'b0;
    #10 rst_n = 1'b1;
    for (int r = 0; r < 8; r++) rd(0, 8'(r * 4), 32'd0, $sformatf("idle_reg%0d", r));
    rd(1, 8'h04, 32'd0, "idle_reload4");

    // Auto-reload on ch0, PRESCALE=1: zero events at E+4, E+8, E+12, ...
    wr(0, 8'h04, 32'd3, 4'hF);
    wr(0, 8'h08, 32'd3, 4'hF);
    wr(0, 8'h00, 32'h7, 4'hF);
    check("ar_e1", 32'(irq1[0]), 32'd0);
    for (int k = 2; k <= 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("ar_edge%0d", k), 32'(irq1[0]), 32'(k == 4));
    end
    wr(0, 8'h0C, 32'h1, 4'hF);
    check("status_clear", 32'(irq1[0]), 32'd0);
    @(posedge clk); #1;
    check("ar_period", 32'(irq1[0]), 32'd1);
    repeat (2) @(posedge clk);
    wr(0, 8'h0C, 32'h1, 4'hF);
    check("clr_vs_zero", 32'(irq1[0]), 32'd1);
    repeat (2) @(posedge clk);
    wr(0, 8'h0C, 32'h1, 4'hF);
    check("clr_mid_period", 32'(irq1[0]), 32'd0);
    wr(0, 8'h00, 32'h6, 4'hF);
    check("en_off_zf_set", 32'(irq1[0]), 32'd1);
    rd(0, 8'h00, 32'h6, "en_off_ctrl");
    rd(0, 8'h08, 32'd3, "en_off_count");

    // COUNT write lands on a decrement edge; two more decrements before the read edge.
    wr(0, 8'h00, 32'h7, 4'hF);
    wr(0, 8'h08, 32'h10, 4'hF);
    rd(0, 8'h08, 32'h0E, "count_wr_wins");
    wr(0, 8'h00, 32'h0, 4'hF);

    // One-shot on ch1.
    wr(0, 8'h18, 32'd5, 4'hF);
    wr(0, 8'h10, 32'h5, 4'hF);
    for (int k = 2; k <= 6; k++) begin
      @(posedge clk); #1;
      check($sformatf("os_edge%0d", k), 32'(irq1[1]), 32'(k == 6));
    end
    rd(0, 8'h10, 32'h4, "os_ctrl");
    rd(0, 8'h18, 32'd0, "os_count");
    repeat (20) @(posedge clk);
    rd(0, 8'h18, 32'd0, "os_count_hold");
    rd(0, 8'h1C, 32'd1, "os_status");

    // Byte-masked writes with ch1 stopped.
    wr(0, 8'h18, 32'h1122_3344, 4'hF);
    wr(0, 8'h18, 32'hAABB_CCDD, 4'b0100);
    rd(0, 8'h18, 32'h11BB_3344, "bytemask_count");
    wr(0, 8'h14, 32'hAABB_CCDD, 4'b1001);
    rd(0, 8'h14, 32'hAA00_00DD, "bytemask_reload");
    wr(0, 8'h10, 32'h7, 4'b0000);
    rd(0, 8'h10, 32'h4, "ctrl_sel0_off");
    check("irq1_ch1_held", 32'(irq1[1]), 32'd1);

    // Prescaler: ch0 of the PRESCALE=4 instance, COUNT=2 one-shot.
    wr(1, 8'h08, 32'd2, 4'hF);
    wr(1, 8'h00, 32'h5, 4'hF);
    e_edge = tb_cyc - 1;
    t1 = e_edge + 1;
    while (t1 % 4 != 0) t1++;
    zero_edge = t1 + 8;
    exp_mid = 2;
    for (int n = e_edge + 1; n <= e_edge + 2; n++) if (n % 4 == 0) exp_mid--;
    rd(1, 8'h08, 32'(exp_mid), "ps_mid_count");
    rise = 0;
    for (int k = 0; k < 16 && rise == 0; k++) begin
      @(posedge clk); #1;
      if (irq4[0]) rise = tb_cyc;
    end
    check("ps_zero_edge", 32'(rise), 32'(zero_edge));
    rd(1, 8'h00, 32'h4, "ps_ctrl");
    rd(1, 8'h08, 32'd0, "ps_count");

    // 4-beat incrementing burst over ch0 registers.
    wr(0, 8'h00, 32'h6, 4'hF);
    wr(0, 8'h0C, 32'h1, 4'hF);
    wr(0, 8'h04, 32'h1234_5678, 4'hF);
    wr(0, 8'h08, 32'hFFFF_FFFF, 4'hF);
    bexp[0] = 32'h6; bexp[1] = 32'h1234_5678; bexp[2] = 32'hFFFF_FFFF; bexp[3] = 32'h0;
    @(posedge clk); #1;
    dsel = 1'b0; cti = 3'b010; we = 1'b0; sel = 4'hF; cyc = 1'b1; stb = 1'b1;
    adr = 32'h0000_0000;
    push_exp(1'b1, bexp[0], "burst0");
    for (int b = 0; b < 4; b++) begin
      @(posedge clk); #1;
      check($sformatf("burst%0d_ack", b), 32'(ack_m), 32'd1);
      if (b < 3) begin
        adr = 32'((b + 1) * 4);
        if (b == 2) cti = 3'b111;
        push_exp(1'b1, bexp[b + 1], $sformatf("burst%0d", b + 1));
      end else begin
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
      end
      @(posedge clk); #1;
      check($sformatf("burst%0d_ack_low", b), 32'(ack_m), 32'd0);
    end

    repeat (3) @(posedge clk);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
